// File: rtl/filter_job_arbiter.sv
// Round-robin scheduler that shares one convolution engine between two frame requesters.
// Define FILTER_ARB_WATCHDOG_EN to abort jobs that stall for TIMEOUT cycles.
module filter_job_arbiter #(
    parameter int WIDTH    = 788,
    parameter int HEIGHT   = 1080,
    parameter int CHANNELS = 3,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_kernel0,
    input  logic [1:0] req_kernel1,
    output logic [1:0] req_grant,
    input  logic [1:0] src_valid,
    input  logic [7:0] src_data0,
    input  logic [7:0] src_data1,
    output logic [1:0] src_ready,
    output logic       eng_start,
    output logic [1:0] eng_kernel_type,
    output logic [7:0] eng_in_data,
    output logic       eng_in_valid,
    input  logic       eng_in_ready,
    input  logic [7:0] eng_out_data,
    input  logic       eng_out_valid,
    output logic       eng_out_ready,
    output logic [7:0] dst_data,
    output logic       dst_valid,
    input  logic       dst_ready,
    output logic       dst_owner,
    output logic       dst_last,
    output logic [1:0] job_done,
    output logic       job_err,
    output logic       busy
);

    localparam logic [31:0] FRAME_BYTES = 32'(WIDTH * HEIGHT * CHANNELS);
    localparam logic [31:0] LAST_BYTE   = FRAME_BYTES - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_START, S_LOAD, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  kernel_q, kernel_d;
    logic        err_q, err_d;
    logic        ptr_q, ptr_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  sel_kernel;
    logic        xfer;
`ifdef FILTER_ARB_WATCHDOG_EN
    localparam logic [31:0] STALL_LAST = 32'(TIMEOUT - 2);
    logic [31:0] stall_q, stall_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            kernel_q <= 2'd0;
            err_q    <= 1'b0;
            ptr_q    <= 1'b0;
            count_q  <= '0;
`ifdef FILTER_ARB_WATCHDOG_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kernel_q <= kernel_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
`ifdef FILTER_ARB_WATCHDOG_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // Every stream moves one byte on a cycle with valid && ready; the arbiter only
    // forwards valid/ready/data combinationally between the owner and the engine.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        kernel_d      = kernel_q;
        err_d         = err_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        req_grant     = 2'b00;
        src_ready     = 2'b00;
        eng_start     = 1'b0;
        eng_in_data   = 8'h00;
        eng_in_valid  = 1'b0;
        eng_out_ready = 1'b0;
        dst_data      = 8'h00;
        dst_valid     = 1'b0;
        dst_last      = 1'b0;
        job_done      = 2'b00;
        job_err       = 1'b0;
        xfer          = 1'b0;
        sel_kernel    = owner_q ? req_kernel1 : req_kernel0;

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    state_d = S_GRANT;
                    owner_d = (req_valid == 2'b11) ? ptr_q : req_valid[1];
                end
            end
            S_GRANT: begin
                req_grant = owner_q ? 2'b10 : 2'b01;
                kernel_d  = sel_kernel;
                err_d     = (sel_kernel == 2'd3);
                state_d   = S_START;
            end
            // A rejected job passes through here without starting the engine.
            S_START: begin
                if (err_q) begin
                    state_d = S_DONE;
                end else begin
                    eng_start = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                eng_in_valid = owner_q ? src_valid[1] : src_valid[0];
                eng_in_data  = owner_q ? src_data1 : src_data0;
                src_ready    = owner_q ? {eng_in_ready, 1'b0} : {1'b0, eng_in_ready};
                xfer         = eng_in_valid && eng_in_ready;
                if (xfer) begin
                    if (count_q == LAST_BYTE) begin
                        count_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                dst_valid     = eng_out_valid;
                dst_data      = eng_out_data;
                eng_out_ready = dst_ready;
                dst_last      = eng_out_valid && (count_q == LAST_BYTE);
                xfer          = eng_out_valid && dst_ready;
                if (xfer) begin
                    if (count_q == LAST_BYTE) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                job_done = owner_q ? 2'b10 : 2'b01;
                job_err  = err_q;
                err_d    = 1'b0;
                ptr_d    = ~owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FILTER_ARB_WATCHDOG_EN
        // The DONE cycle itself is the TIMEOUT-th cycle without a transfer.
        stall_d = '0;
        if (state_q == S_LOAD || state_q == S_DRAIN) begin
            if (xfer) begin
                stall_d = '0;
            end else if (stall_q == STALL_LAST) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                count_d = '0;
            end else begin
                stall_d = stall_q + 32'd1;
            end
        end
`endif
    end

    assign eng_kernel_type = kernel_q;
    assign dst_owner       = owner_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_job_arbiter.sv
// Self-checking bench for filter_job_arbiter with a small frame (4x2x3 = 24 bytes).
// The engine is a bench-side byte queue that adds a kernel-dependent offset to each byte.
module tb_filter_job_arbiter;
  localparam int FB = 24;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid, req_kernel0, req_kernel1, req_grant;
  logic [1:0] src_valid, src_ready;
  logic [7:0] src_data0, src_data1;
  logic       eng_start;
  logic [1:0] eng_kernel_type;
  logic [7:0] eng_in_data, eng_out_data, dst_data;
  logic       eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
  logic       dst_valid, dst_ready, dst_owner, dst_last, job_err, busy;
  logic [1:0] job_done;

  filter_job_arbiter #(.WIDTH(4), .HEIGHT(2), .CHANNELS(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_kernel0(req_kernel0), .req_kernel1(req_kernel1),
    .req_grant(req_grant),
    .src_valid(src_valid), .src_data0(src_data0), .src_data1(src_data1), .src_ready(src_ready),
    .eng_start(eng_start), .eng_kernel_type(eng_kernel_type),
    .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
    .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
    .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_owner(dst_owner), .dst_last(dst_last),
    .job_done(job_done), .job_err(job_err), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_p = 100, eir_p = 100, eov_p = 100, dst_p = 100;
  bit dst_hold = 0;
  int last_served = 1;

  logic [7:0] src_q0[$], src_q1[$], eng_q[$];
  logic [7:0] exp0[FB], exp1[FB];
  logic [7:0] in_log[$], dst_log[$];
  logic       last_log[$], own_log[$], done_err[$];
  logic [1:0] grant_mask[$], start_kernel[$], done_mask[$];
  int         grant_cyc[$], start_cyc[$], done_cyc[$];
  int         last_dst_cyc, nonowner_rdy, eor_bad;

  function automatic logic [7:0] xf(logic [7:0] b, logic [1:0] k);
    return b + 8'(17 * (int'(k) + 1));
  endfunction

  // Round-robin reference: both requesting -> the one not served last.
  function automatic logic [1:0] rr_pick(logic [1:0] req, int last);
    if (req == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return req;
  endfunction

  // driver tasks
  task automatic drive_inputs();
    src_valid[0] = (src_q0.size() > 0) && ($urandom_range(99) < src_p);
    src_valid[1] = (src_q1.size() > 0) && ($urandom_range(99) < src_p);
    src_data0    = (src_q0.size() > 0) ? src_q0[0] : 8'($urandom);
    src_data1    = (src_q1.size() > 0) ? src_q1[0] : 8'($urandom);
    eng_in_ready = ($urandom_range(99) < eir_p);
    eng_out_valid = (eng_q.size() > 0) && ($urandom_range(99) < eov_p);
    eng_out_data  = (eng_q.size() > 0) ? eng_q[0] : 8'h00;
    dst_ready    = !dst_hold && ($urandom_range(99) < dst_p);
  endtask

  task automatic step();
    bit in_x, out_x, s0_x, s1_x;
    logic [1:0] g, k;
    logic [7:0] b;
    #1;
    in_x = eng_in_valid && eng_in_ready;
    out_x = eng_out_valid && eng_out_ready;
    s0_x = src_valid[0] && src_ready[0];
    s1_x = src_valid[1] && src_ready[1];
    g = req_grant;
    k = eng_kernel_type;
    b = eng_in_data;
    if (in_x) in_log.push_back(b);
    if (dst_valid && dst_ready) begin
      dst_log.push_back(dst_data);
      last_log.push_back(dst_last);
      own_log.push_back(dst_owner);
      last_dst_cyc = cyc;
    end
    if (out_x != (dst_valid && dst_ready)) eor_bad++;
    if (src_ready[dst_owner ? 0 : 1]) nonowner_rdy++;
    if (g != 2'b00) begin grant_cyc.push_back(cyc); grant_mask.push_back(g); end
    if (eng_start) begin start_cyc.push_back(cyc); start_kernel.push_back(k); end
    if (job_done != 2'b00) begin
      done_cyc.push_back(cyc); done_mask.push_back(job_done); done_err.push_back(job_err);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (s0_x) void'(src_q0.pop_front());
    if (s1_x) void'(src_q1.pop_front());
    if (in_x) eng_q.push_back(xf(b, k));
    if (out_x) void'(eng_q.pop_front());
    req_valid = req_valid & ~g;
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (done_cyc.size() < n) begin
      errors++;
      $display("FAIL %s_wait job_done count got=%0d exp=%0d", tag, done_cyc.size(), n);
    end
  endtask

  task automatic clear_logs();
    in_log.delete(); dst_log.delete(); last_log.delete(); own_log.delete();
    grant_cyc.delete(); grant_mask.delete(); start_cyc.delete(); start_kernel.delete();
    done_cyc.delete(); done_mask.delete(); done_err.delete();
    nonowner_rdy = 0; eor_bad = 0; last_dst_cyc = -1;
  endtask

  task automatic gen_frame(input int who, input int n);
    for (int i = 0; i < FB; i++) begin
      if (who == 0) exp0[i] = 8'($urandom); else exp1[i] = 8'($urandom);
    end
    for (int i = 0; i < n; i++) begin
      if (who == 0) src_q0.push_back(exp0[i]); else src_q1.push_back(exp1[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; req_kernel0 = 2'd0; req_kernel1 = 2'd0;
    src_q0.delete(); src_q1.delete(); eng_q.delete();
    dst_hold = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_served = 1;
  endtask

  // tests
  task automatic test_reset();
    logic [31:0] outs;
    reset = 1'b1;
    req_valid = 2'b11; req_kernel0 = 2'd1; req_kernel1 = 2'd2;
    src_valid = 2'b11; src_data0 = 8'hAA; src_data1 = 8'h55;
    eng_in_ready = 1'b1; eng_out_valid = 1'b1; eng_out_data = 8'hC3; dst_ready = 1'b1;
    #3;
    outs = {req_grant, src_ready, eng_start, eng_kernel_type, eng_in_data, eng_in_valid,
            eng_out_ready, dst_data, dst_valid, dst_owner, dst_last, job_done, job_err, busy};
    checks++;
    if (outs !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    do_reset();
    repeat (3) step();
    outs = {req_grant, src_ready, eng_start, eng_kernel_type, eng_in_data, eng_in_valid,
            eng_out_ready, dst_data, dst_valid, dst_owner, dst_last, job_done, job_err, busy};
    checks++;
    if (outs !== 32'h0) begin
      errors++; $display("FAIL reset_idle_outputs got=%h exp=0", outs);
    end
  endtask

  task automatic test_single_job();
    int req_cyc;
    clear_logs();
    src_p = 100; eir_p = 100; eov_p = 100; dst_p = 100;
    gen_frame(0, FB);
    req_kernel0 = 2'd1;
    req_valid = rr_pick(2'b01, last_served);
    req_cyc = cyc;
    drive_inputs();
    wait_done(1, 300, "single");
    last_served = 0;
    checks++;
    if (grant_mask.size() != 1 || grant_mask[0] !== 2'b01 || grant_cyc[0] != req_cyc + 1) begin
      errors++; $display("FAIL single_grant n=%0d cyc=%0d exp_cyc=%0d", grant_mask.size(),
                         grant_cyc.size() ? grant_cyc[0] : -1, req_cyc + 1);
    end
    checks++;
    if (start_cyc.size() != 1 || start_cyc[0] != req_cyc + 2 || start_kernel[0] !== 2'd1) begin
      errors++; $display("FAIL single_start n=%0d kernel=%0d exp n=1 kernel=1", start_cyc.size(),
                         start_kernel.size() ? start_kernel[0] : 2'bxx);
    end
    checks++;
    if (in_log.size() != FB) begin
      errors++; $display("FAIL single_in_count got=%0d exp=%0d", in_log.size(), FB);
    end
    for (int i = 0; i < FB && i < in_log.size(); i++) begin
      checks++;
      if (in_log[i] !== exp0[i]) begin
        errors++; $display("FAIL single_in_byte%0d got=%h exp=%h", i, in_log[i], exp0[i]);
      end
    end
    checks++;
    if (dst_log.size() != FB) begin
      errors++; $display("FAIL single_dst_count got=%0d exp=%0d", dst_log.size(), FB);
    end
    for (int i = 0; i < FB && i < dst_log.size(); i++) begin
      checks++;
      if (dst_log[i] !== xf(exp0[i], 2'd1) || own_log[i] !== 1'b0 || last_log[i] !== (i == FB - 1)) begin
        errors++; $display("FAIL single_dst_byte%0d got=%h/%b/%b exp=%h/0/%b", i, dst_log[i],
                           own_log[i], last_log[i], xf(exp0[i], 2'd1), i == FB - 1);
      end
    end
    checks++;
    if (done_mask.size() != 1 || done_mask[0] !== 2'b01 || done_err[0] !== 1'b0 ||
        done_cyc[0] != last_dst_cyc + 1) begin
      errors++; $display("FAIL single_done cyc=%0d exp=%0d", done_cyc.size() ? done_cyc[0] : -1,
                         last_dst_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_first, exp_second;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      clear_logs();
      src_p = 100; eir_p = 100; eov_p = 100; dst_p = 100;
      gen_frame(0, FB); gen_frame(1, FB);
      req_kernel0 = 2'd0; req_kernel1 = 2'd2;
      req_valid = 2'b11;
      exp_first = rr_pick(2'b11, last_served);
      exp_second = 2'b11 & ~exp_first;
      drive_inputs();
      wait_done(2, 600, "rr");
      last_served = exp_second[1] ? 1 : 0;
      checks++;
      if (grant_mask.size() != 2 || grant_mask[0] !== exp_first || grant_mask[1] !== exp_second) begin
        errors++; $display("FAIL rr_order round=%0d got=%b,%b exp=%b,%b", round,
                           grant_mask.size() > 0 ? grant_mask[0] : 2'bxx,
                           grant_mask.size() > 1 ? grant_mask[1] : 2'bxx, exp_first, exp_second);
      end
      checks++;
      if (grant_cyc.size() != 2 || done_cyc.size() < 1 || grant_cyc[1] - done_cyc[0] < 2) begin
        errors++; $display("FAIL rr_gap round=%0d grant-done gap too small", round);
      end
      for (int i = 0; i < 2 * FB; i++) begin
        logic [7:0] e;
        e = (i < FB) ? xf(exp0[i], 2'd0) : xf(exp1[i - FB], 2'd2);
        checks++;
        if (i >= dst_log.size() || dst_log[i] !== e || own_log[i] !== (i >= FB)) begin
          errors++; $display("FAIL rr_dst round=%0d idx=%0d got=%h exp=%h", round, i,
                             i < dst_log.size() ? dst_log[i] : 8'hxx, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    src_p = 75; eir_p = 75; eov_p = 75; dst_p = 75;
    gen_frame(0, FB); gen_frame(1, FB);
    req_kernel0 = 2'd2;
    req_valid = 2'b01;
    drive_inputs();
    wait_done(1, 1000, "bp");
    last_served = 0;
    src_q1.delete();
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (i >= in_log.size() || in_log[i] !== exp0[i] || i >= dst_log.size() ||
          dst_log[i] !== xf(exp0[i], 2'd2)) begin
        errors++; $display("FAIL bp_byte%0d in=%h dst=%h exp_in=%h exp_dst=%h", i,
                           i < in_log.size() ? in_log[i] : 8'hxx,
                           i < dst_log.size() ? dst_log[i] : 8'hxx, exp0[i], xf(exp0[i], 2'd2));
      end
    end
    checks++;
    if (in_log.size() != FB || dst_log.size() != FB) begin
      errors++; $display("FAIL bp_counts in=%0d dst=%0d exp=%0d", in_log.size(), dst_log.size(), FB);
    end
    checks++;
    if (nonowner_rdy != 0) begin
      errors++; $display("FAIL bp_nonowner_ready cycles=%0d exp=0", nonowner_rdy);
    end
    checks++;
    if (eor_bad != 0) begin
      errors++; $display("FAIL bp_eng_out_ready_outside_drain cycles=%0d exp=0", eor_bad);
    end
  endtask

  task automatic test_dst_hold();
    int k = 0;
    clear_logs();
    src_p = 100; eir_p = 100; eov_p = 100; dst_p = 100;
    gen_frame(0, FB);
    req_kernel0 = 2'd0;
    req_valid = 2'b01;
    drive_inputs();
    while (dst_log.size() < 8 && k < 200) begin step(); k++; end
    dst_hold = 1;
    drive_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (eng_out_ready !== 1'b0 || dst_valid !== 1'b1 || dst_data !== xf(exp0[8], 2'd0)) begin
        errors++; $display("FAIL hold_cycle%0d ready=%b valid=%b data=%h exp 0/1/%h", i,
                           eng_out_ready, dst_valid, dst_data, xf(exp0[8], 2'd0));
      end
      step();
    end
    dst_hold = 0;
    drive_inputs();
    wait_done(1, 300, "hold");
    last_served = 0;
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (i >= dst_log.size() || dst_log[i] !== xf(exp0[i], 2'd0)) begin
        errors++; $display("FAIL hold_dst_byte%0d got=%h exp=%h", i,
                           i < dst_log.size() ? dst_log[i] : 8'hxx, xf(exp0[i], 2'd0));
      end
    end
  endtask

  task automatic test_reject();
    clear_logs();
    req_kernel1 = 2'd3;
    req_valid = 2'b10;
    drive_inputs();
    wait_done(1, 50, "reject");
    repeat (3) step();
    last_served = 1;
    checks++;
    if (grant_mask.size() != 1 || grant_mask[0] !== 2'b10) begin
      errors++; $display("FAIL reject_grant n=%0d exp grant=10", grant_mask.size());
    end
    checks++;
    if (start_cyc.size() != 0 || in_log.size() != 0) begin
      errors++; $display("FAIL reject_no_start starts=%0d bytes=%0d exp=0", start_cyc.size(), in_log.size());
    end
    checks++;
    if (done_mask.size() != 1 || done_mask[0] !== 2'b10 || done_err[0] !== 1'b1 ||
        grant_cyc.size() != 1 || done_cyc[0] != grant_cyc[0] + 2) begin
      errors++; $display("FAIL reject_done n=%0d mask=%b err=%b exp 1/10/1 at grant+2", done_mask.size(),
                         done_mask.size() ? done_mask[0] : 2'bxx, done_err.size() ? done_err[0] : 1'bx);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] outs;
    int k = 0;
    clear_logs();
    src_p = 100; eir_p = 100; eov_p = 100; dst_p = 100;
    gen_frame(0, FB);
    req_kernel0 = 2'd1;
    req_valid = 2'b01;
    drive_inputs();
    while (in_log.size() < 12 && k < 100) begin step(); k++; end
    #2;
    reset = 1'b1;
    #1;
    outs = {req_grant, src_ready, eng_start, eng_kernel_type, eng_in_data, eng_in_valid,
            eng_out_ready, dst_data, dst_valid, dst_owner, dst_last, job_done, job_err, busy};
    checks++;
    if (outs !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0", outs);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (job_done !== 2'b00 || eng_start !== 1'b0) begin
        errors++; $display("FAIL midreset_no_done done=%b start=%b exp=00/0", job_done, eng_start);
      end
    end
    do_reset();
    clear_logs();
    gen_frame(0, FB);
    req_kernel0 = 2'd1;
    req_valid = 2'b01;
    drive_inputs();
    wait_done(1, 300, "midreset");
    last_served = 0;
    checks++;
    if (in_log.size() != FB || done_mask.size() != 1 || start_cyc.size() != 1) begin
      errors++; $display("FAIL midreset_restart bytes=%0d dones=%0d starts=%0d exp=%0d/1/1",
                         in_log.size(), done_mask.size(), start_cyc.size(), FB);
    end
    for (int i = 0; i < FB && i < in_log.size(); i++) begin
      checks++;
      if (in_log[i] !== exp0[i]) begin
        errors++; $display("FAIL midreset_byte%0d got=%h exp=%h", i, in_log[i], exp0[i]);
      end
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int t5;
    clear_logs();
    src_p = 100; eir_p = 100; eov_p = 100; dst_p = 100;
    gen_frame(0, 5);
    req_kernel0 = 2'd0;
    req_valid = 2'b01;
    drive_inputs();
    while (in_log.size() < 5 && k < 100) begin step(); k++; end
    t5 = cyc - 1;
`ifdef FILTER_ARB_WATCHDOG_EN
    wait_done(1, 100, "watchdog");
    step();
    eng_q.delete();
    last_served = 0;
    checks++;
    if (done_mask.size() != 1 || done_mask[0] !== 2'b01 || done_err[0] !== 1'b1 ||
        done_cyc[0] != t5 + 16) begin
      errors++; $display("FAIL watchdog_abort at=%0d exp=%0d", done_cyc.size() ? done_cyc[0] : -1, t5 + 16);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL watchdog_idle busy got=%b exp=0", busy); end
`else
    repeat (100) step();
    checks++;
    if (done_cyc.size() != 0 || busy !== 1'b1 || in_log.size() != 5) begin
      errors++; $display("FAIL stall_no_abort dones=%0d busy=%b bytes=%0d exp 0/1/5 since %0d",
                         done_cyc.size(), busy, in_log.size(), t5);
    end
    for (int i = 5; i < FB; i++) src_q0.push_back(exp0[i]);
    drive_inputs();
    wait_done(1, 300, "stall");
    last_served = 0;
    checks++;
    if (in_log.size() != FB || done_err.size() != 1 || done_err[0] !== 1'b0) begin
      errors++; $display("FAIL stall_resume bytes=%0d err=%b exp=%0d/0", in_log.size(),
                         done_err.size() ? done_err[0] : 1'bx, FB);
    end
    for (int i = 0; i < FB && i < dst_log.size(); i++) begin
      checks++;
      if (dst_log[i] !== xf(exp0[i], 2'd0)) begin
        errors++; $display("FAIL stall_dst_byte%0d got=%h exp=%h", i, dst_log[i], xf(exp0[i], 2'd0));
      end
    end
`endif
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_dst_hold();
    test_reject();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
